dict_loader: RTL

Boot-time loader for the three compression dictionaries (field1/field2/field3). After `start`, it fetches a packed dictionary image from memory one word per entry using the same valid/ready read handshake as the cache controller. It appends each entry to the matching dictionary via that dictionary's `write_enable`/`write_val` port. It sits upstream of the compressing fetch controller, and top level holds processor fetch until `load_done` is high.

---
 rtl/dict_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dict_loader.sv
// Boot-time loader: fetches the packed field1/field2/field3 dictionary image
// word by word over a valid/ready read port and appends each entry to its dictionary.
module dict_loader #(
  parameter int unsigned FIELD1_KEY_WIDTH = 3,
  parameter int unsigned FIELD2_KEY_WIDTH = 5,
  parameter int unsigned FIELD3_KEY_WIDTH = 8,
  parameter int unsigned FIELD1_VAL_WIDTH = 7,
  parameter int unsigned FIELD2_VAL_WIDTH = 10,
  parameter int unsigned FIELD3_VAL_WIDTH = 15,
  parameter logic [31:0] DICT_BASE_ADDR   = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        load_busy,
  output logic                        load_done,
  output logic                        load_error,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

  localparam int unsigned N1    = 1 << FIELD1_KEY_WIDTH;
  localparam int unsigned N2    = 1 << FIELD2_KEY_WIDTH;
  localparam int unsigned N3    = 1 << FIELD3_KEY_WIDTH;
  localparam int unsigned TOTAL = N1 + N2 + N3;
  localparam int unsigned IDX_W = $clog2(TOTAL);
  localparam logic [31:0] BASE  = {DICT_BASE_ADDR[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] index;
  logic             last, sel1, sel2, ovf;

  assign last = (index == IDX_W'(TOTAL - 1));
  assign sel1 = (index < IDX_W'(N1));
  assign sel2 = !sel1 && (index < IDX_W'(N1 + N2));

  always_comb begin
    ovf = 1'b0;
    if (sel1)      ovf = ((mem_req_rdata >> FIELD1_VAL_WIDTH) != '0);
    else if (sel2) ovf = ((mem_req_rdata >> FIELD2_VAL_WIDTH) != '0);
    else           ovf = ((mem_req_rdata >> FIELD3_VAL_WIDTH) != '0);
  end

  assign load_busy = (state == REQ) || (state == WRITE);
  assign load_done = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (mem_req_ready) state_next = WRITE;
      WRITE:   state_next = last ? DONE : REQ;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      index              <= '0;
      mem_req_valid      <= 1'b0;
      mem_req_addr       <= '0;
      load_error         <= 1'b0;
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      dict1_write_val    <= '0;
      dict2_write_val    <= '0;
      dict3_write_val    <= '0;
    end else begin
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          index         <= '0;
          mem_req_valid <= 1'b1;
          mem_req_addr  <= BASE;
        end
        REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          if (ovf) load_error <= 1'b1;
          if (sel1) begin
            dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
            dict1_write_enable <= 1'b1;
          end else if (sel2) begin
            dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
            dict2_write_enable <= 1'b1;
          end else begin
            dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
            dict3_write_enable <= 1'b1;
          end
        end
        WRITE: begin
          index <= index + 1'b1;
          // Address advances incrementally; equals base + 4*index mod 2^32.
          if (!last) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= mem_req_addr + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
